pn_spreader: RTL

Transmit-side partner of the chip-rate correlator. Generates a maximal-length PN code from an LFSR, spreads one data bit per code epoch (sig = code XOR data), and emits a one-clock capture strobe on the first clock of every epoch. The strobe aligns the correlator's integration window with the code period. Sits in the DSP test chain and drives the correlator's sig/code/capture inputs directly or through the analog loopback.

---
 rtl/pn_pkg.sv | 49 ++++
 rtl/pn_lfsr.sv | 32 +++
 rtl/pn_spreader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - shared state encoding, default LFSR masks and period helper for the PN spreader
package pn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pn_state_e;

    localparam int PN_MIN_W = 3;
    localparam int PN_MAX_W = 10;

    // Fibonacci masks for maximal-length sequences, bit i = state[i] in the parity
    function automatic logic [15:0] default_taps(input int n);
        case (n)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            default: return 16'h0006;
        endcase
    endfunction

    function automatic logic [15:0] default_taps_b(input int n);
        case (n)
            3:       return 16'h0005;
            4:       return 16'h0009;
            5:       return 16'h001E;
            6:       return 16'h0021;
            7:       return 16'h0044;
            8:       return 16'h008E;
            9:       return 16'h0108;
            10:      return 16'h0204;
            default: return 16'h0005;
        endcase
    endfunction

    function automatic logic [15:0] default_seed(input int n);
        return (n >= PN_MIN_W && n <= PN_MAX_W) ? 16'h0001 : 16'h0001;
    endfunction

    function automatic int pn_period(input int n);
        return (1 << n) - 1;
    endfunction

endpackage

// File: rtl/pn_lfsr.sv
// rtl/pn_lfsr.sv - Fibonacci LFSR with synchronous seed load; a zero seed is replaced by 1
module pn_lfsr
    import pn_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] TAPS = W'(default_taps(W)),
    parameter logic [W-1:0] SEED = W'(default_seed(W))
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic bit_out
);

    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    logic [W-1:0] state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED_EFF;
        end else if (load) begin
            state <= SEED_EFF;
        end else if (step) begin
            state <= {state[W-2:0], ^(state & TAPS)};
        end
    end

    assign bit_out = state[W-1];

endmodule

// File: rtl/pn_spreader.sv
// rtl/pn_spreader.sv - PN code spreader with per-epoch data bit and capture strobe; GOLD_CODE_EN adds a second LFSR
module pn_spreader
    import pn_pkg::*;
#(
    parameter int                LFSR_W   = 7,
    parameter logic [LFSR_W-1:0] TAPS     = 7'h60,
    parameter logic [LFSR_W-1:0] SEED     = 7'h01,
    parameter int                CHIP_DIV = 1,
    parameter logic [LFSR_W-1:0] TAPS_B   = 7'h44
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic data_in,
    input  logic data_valid,
    output logic data_ready,
    output logic code,
    output logic sig,
    output logic capture,
    output logic underrun,
    output logic active
);

    localparam logic [0:0] S_IDLE    = ST_IDLE;
    localparam logic [0:0] S_RUN     = ST_RUN;
    localparam int         LAST_CHIP = pn_period(LFSR_W) - 1;

    logic [0:0]        state;
    logic [LFSR_W-1:0] chip_idx;
    logic [7:0]        div_cnt;
    logic              data_bit;
    logic              cap_r;
    logic              und_r;

    logic run;
    logic chip_end;
    logic epoch_end;
    logic handshake;
    logic lfsr_load;
    logic lfsr_step;
    logic pn_bit;

    assign run       = (state == S_RUN);
    assign chip_end  = (div_cnt == 8'(CHIP_DIV - 1));
    assign epoch_end = run && chip_end && (chip_idx == LFSR_W'(LAST_CHIP));
    assign handshake = run ? epoch_end : en;

    // The LFSR sits at SEED whenever idle and is reloaded on every epoch boundary
    assign lfsr_load = !run || epoch_end;
    assign lfsr_step = run && chip_end && !epoch_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            chip_idx <= '0;
            div_cnt  <= '0;
            data_bit <= 1'b0;
            cap_r    <= 1'b0;
            und_r    <= 1'b0;
        end else begin
            cap_r <= handshake && en;
            if (handshake) begin
                data_bit <= data_valid & data_in;
                if (!data_valid) begin
                    und_r <= 1'b1;
                end
            end
            if (!run) begin
                chip_idx <= '0;
                div_cnt  <= '0;
                if (en) begin
                    state <= S_RUN;
                end
            end else if (chip_end) begin
                div_cnt <= '0;
                if (epoch_end) begin
                    chip_idx <= '0;
                    if (!en) begin
                        state <= S_IDLE;
                    end
                end else begin
                    chip_idx <= chip_idx + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    logic bit_a;

    pn_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr_a (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .bit_out (bit_a)
    );

`ifdef GOLD_CODE_EN
    logic bit_b;

    pn_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS_B),
        .SEED (SEED)
    ) u_lfsr_b (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .bit_out (bit_b)
    );

    assign pn_bit = bit_a ^ bit_b;
`else
    assign pn_bit = bit_a;
`endif

    // In reset the idle handshake is suppressed so every output reads 0
    assign data_ready = run ? epoch_end : (en && rst);
    assign code       = run && pn_bit;
    assign sig        = run && (pn_bit ^ data_bit);
    assign capture    = cap_r;
    assign underrun   = und_r;
    assign active     = run;

endmodule
